// File: rtl/sdram_port_arbiter_if.sv
// rtl/sdram_port_arbiter_if.sv - requester and controller-side signals of the SDRAM port arbiter
// master = clients plus controller model, slave = arbiter.
interface sdram_port_arbiter_if #(
  parameter int AW = 24
);
  logic          p0_req, p0_we, p0_ack;
  logic [AW-1:0] p0_addr;
  logic [15:0]   p0_din, p0_dout;
  logic [1:0]    p0_ds;
  logic          p1_req, p1_we, p1_ack;
  logic [AW-1:0] p1_addr;
  logic [15:0]   p1_din, p1_dout;
  logic [1:0]    p1_ds;
  logic          p2_req, p2_we, p2_ack;
  logic [AW-1:0] p2_addr;
  logic [15:0]   p2_din, p2_dout;
  logic [1:0]    p2_ds;
  logic          mem_req, mem_rfsh, mem_we, mem_ack, busy;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_din, mem_dout;
  logic [1:0]    mem_ds;

  modport master (
    output p0_req, p0_we, p0_addr, p0_din, p0_ds,
    output p1_req, p1_we, p1_addr, p1_din, p1_ds,
    output p2_req, p2_we, p2_addr, p2_din, p2_ds,
    input  p0_ack, p0_dout, p1_ack, p1_dout, p2_ack, p2_dout,
    input  mem_req, mem_rfsh, mem_we, mem_addr, mem_din, mem_ds, busy,
    output mem_ack, mem_dout
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_din, p0_ds,
    input  p1_req, p1_we, p1_addr, p1_din, p1_ds,
    input  p2_req, p2_we, p2_addr, p2_din, p2_ds,
    output p0_ack, p0_dout, p1_ack, p1_dout, p2_ack, p2_dout,
    output mem_req, mem_rfsh, mem_we, mem_addr, mem_din, mem_ds, busy,
    input  mem_ack, mem_dout
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - three-port SDRAM command arbiter with auto-refresh scheduling
// Serialises download, CPU and video accesses plus refresh onto one controller command port.
module sdram_port_arbiter #(
  parameter int AW               = 24,
  parameter int REFRESH_INTERVAL = 384,
  parameter int REFRESH_MAX      = 3
) (
  input  logic                clk_sys,
  input  logic                reset,
  sdram_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(REFRESH_INTERVAL);
  localparam int PW = $clog2(REFRESH_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  typedef enum logic [1:0] {G_P0, G_P1, G_P2, G_RFSH} grant_t;

  state_t        state_q, state_d;
  grant_t        grant_q, grant_d, sel;
  logic          take, rfsh_grant, rexp;
  logic          rr_q, rr_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          mem_req_q, mem_req_d, mem_rfsh_q, mem_rfsh_d;
  logic          mem_we_q, mem_we_d, busy_q, busy_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]   mem_din_q, mem_din_d;
  logic [1:0]    mem_ds_q, mem_ds_d;
  logic [2:0]    ack_q, ack_d;
  logic [15:0]   dout_q [3];
  logic [15:0]   dout_d [3];

  // rr_q = 0 points at the CPU, 1 at video; only moves when both contend.
  always_comb begin
    take = 1'b1;
    sel  = G_P0;
    rr_d = rr_q;
    if (pend_q != '0) begin
      sel = G_RFSH;
    end else if (bus.p0_req) begin
      sel = G_P0;
    end else if (bus.p1_req && bus.p2_req) begin
      sel  = rr_q ? G_P2 : G_P1;
      rr_d = ~rr_q;
    end else if (bus.p1_req) begin
      sel = G_P1;
    end else if (bus.p2_req) begin
      sel = G_P2;
    end else begin
      take = 1'b0;
    end
    if (state_q != S_IDLE) begin
      take = 1'b0;
      rr_d = rr_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    mem_req_d  = 1'b0;
    mem_rfsh_d = mem_rfsh_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_ds_d   = mem_ds_q;
    busy_d     = busy_q;
    ack_d      = '0;
    dout_d     = dout_q;

    rexp       = (rcnt_q == '0);
    rcnt_d     = rexp ? CW'(REFRESH_INTERVAL - 1) : rcnt_q - 1'b1;
    rfsh_grant = take && (sel == G_RFSH);
    pend_d     = pend_q;
    if (rexp && !rfsh_grant) begin
      if (pend_q != PW'(REFRESH_MAX)) pend_d = pend_q + 1'b1;
    end else if (!rexp && rfsh_grant) begin
      pend_d = pend_q - 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (take) begin
          state_d    = S_ISSUE;
          grant_d    = sel;
          mem_req_d  = 1'b1;
          busy_d     = 1'b1;
          mem_rfsh_d = (sel == G_RFSH);
          case (sel)
            G_P0: begin
              mem_we_d = bus.p0_we; mem_addr_d = bus.p0_addr;
              mem_din_d = bus.p0_din; mem_ds_d = bus.p0_ds;
            end
            G_P1: begin
              mem_we_d = bus.p1_we; mem_addr_d = bus.p1_addr;
              mem_din_d = bus.p1_din; mem_ds_d = bus.p1_ds;
            end
            G_P2: begin
              mem_we_d = bus.p2_we; mem_addr_d = bus.p2_addr;
              mem_din_d = bus.p2_din; mem_ds_d = bus.p2_ds;
            end
            default: begin
              mem_we_d = 1'b0; mem_addr_d = '0;
              mem_din_d = '0; mem_ds_d = '0;
            end
          endcase
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.mem_ack) begin
          state_d    = S_IDLE;
          busy_d     = 1'b0;
          mem_rfsh_d = 1'b0;
          case (grant_q)
            G_P0: begin ack_d[0] = 1'b1; if (!mem_we_q) dout_d[0] = bus.mem_dout; end
            G_P1: begin ack_d[1] = 1'b1; if (!mem_we_q) dout_d[1] = bus.mem_dout; end
            G_P2: begin ack_d[2] = 1'b1; if (!mem_we_q) dout_d[2] = bus.mem_dout; end
            default: ;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      grant_q    <= G_P0;
      rr_q       <= 1'b0;
      rcnt_q     <= CW'(REFRESH_INTERVAL - 1);
      pend_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_rfsh_q <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_ds_q   <= '0;
      busy_q     <= 1'b0;
      ack_q      <= '0;
      dout_q     <= '{16'h0, 16'h0, 16'h0};
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      rcnt_q     <= rcnt_d;
      pend_q     <= pend_d;
      mem_req_q  <= mem_req_d;
      mem_rfsh_q <= mem_rfsh_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_ds_q   <= mem_ds_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      dout_q     <= dout_d;
    end
  end

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_rfsh = mem_rfsh_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.mem_ds   = mem_ds_q;
  assign bus.busy     = busy_q;
  assign bus.p0_ack   = ack_q[0];
  assign bus.p1_ack   = ack_q[1];
  assign bus.p2_ack   = ack_q[2];
  assign bus.p0_dout  = dout_q[0];
  assign bus.p1_dout  = dout_q[1];
  assign bus.p2_dout  = dout_q[2];
endmodule
